addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
Multi-channel signed add/subtract unit with a configurable-depth elastic pipeline and full valid/ready flow control. Each accepted transaction computes a+b or a-b on all channels in parallel, at full width. It is the parametrised successor of the single-cycle subtract block. It sits between sample-producing stages (mixers, filters) and downstream consumers in the demodulator datapath.

Parameters:
DATA_W, 24, signed input width per channel
NUM_CH, 2, number of parallel channels
LAT, 2, pipeline depth in cycles (>=1); LAT<1 is an elaboration error

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
i_valid  in  1  input transaction valid
o_ready  out  1  block can accept input this cycle
i_sub  in  1  mode for this transaction: 1 = a-b, 0 = a+b
i_a  in  NUM_CH*DATA_W  packed signed operand A; channel n at [n*DATA_W +: DATA_W]
i_b  in  NUM_CH*DATA_W  packed signed operand B, same packing
o_c  out  NUM_CH*(DATA_W+1)  packed signed result; channel n at [n*(DATA_W+1) +: DATA_W+1]
o_sat  out  NUM_CH  per-channel saturation flag (see Optional Feature)
o_valid  out  1  output transaction valid
i_ready  in  1  downstream accepts output this cycle

Behaviour:
- Reset (reset_n=0, async assert): all stage valid bits=0, all stage data=0; o_valid=0, o_c=0, o_sat=0. Release is synchronous to clk. Reset mid-operation discards all in-flight transactions.
- Pipeline: LAT register stages S0..S(LAT-1). Each stage has a valid bit v[k] and holds data + sat flags. Output is taken from S(LAT-1): o_valid=v[LAT-1].
- Ready chain: rdy[LAT]=i_ready; rdy[k] = !v[k] || rdy[k+1]; o_ready=rdy[0]. This path is combinational. Bubbles collapse, so a stalled output does not block empty stages.
- Input accept when i_valid && o_ready. S0 loads the computed result, and v[0] follows: v[0] <= i_valid whenever rdy[0].
- Stage k>0: when rdy[k], load S(k-1) data and set v[k] <= v[k-1]. Otherwise hold data and valid.
- Output handshake: a transfer completes when o_valid && i_ready. o_c and o_valid must stay stable while o_valid && !i_ready.
- Latency: LAT cycles from accept to o_valid with no stall. Throughput is 1 transaction/cycle when i_ready is held high.
- Arithmetic: both operands are sign-extended to DATA_W+1, then a+b or a-b is computed per i_sub. The result is exact and never wraps. The mode is captured per transaction; mixed modes in flight are legal.
- Full: all v=1 and i_ready=0 -> o_ready=0; no stage changes.
- Simultaneous drain and fill when full: i_ready=1 and i_valid=1 -> output retires and the new input is accepted in the same cycle.
- i_valid=0 with o_ready=1: an empty bubble enters S0; no data corruption of downstream stages.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: each channel result is clamped to the DATA_W signed range [-2^(DATA_W-1), 2^(DATA_W-1)-1], then sign-extended into the DATA_W+1 output field. o_sat[n]=1 when channel n was clamped. The flag is pipelined with the data.
- Not defined: full-width exact result; o_sat is tied to 0.

Test Plan:
- Reset/latency: reset_n=0 mid-stream, then release, then send a=100,b=30,i_sub=1 with i_ready=1 -> o_valid=0 during reset. After release, o_c ch=70 appears exactly 2 cycles after accept.
- Mode/sign: ch0 a=-5,b=7,sub -> -12; ch1 a=-8388608,b=-1,add -> -8388609 (no saturation build). Back-to-back add then sub -> results in order.
- Backpressure: stream 5 transactions, i_ready=0 for 4 cycles -> o_ready drops after 2 pending accepts. o_c/o_valid stay stable. No loss or duplication; order is preserved.
- Bubble collapse: single transaction, i_ready=0, i_valid idle -> o_ready stays 1 until both stages are valid.
- Full throughput: i_valid=1, i_ready=1 for 10 cycles with LAT=2 -> 10 outputs on consecutive cycles, values a-b correct per channel.
- Saturation (ADDSUB_SATURATE_EN): a=8388607,b=-1,sub -> o_c=8388607, o_sat[ch]=1; without the macro -> o_c=8388608, o_sat=0.

Source files
------------

// File: rtl/addsub_pipe.sv
// Multi-channel signed add/subtract with an elastic valid/ready pipeline of LAT stages.
// Optional clamping to the DATA_W signed range is enabled by defining ADDSUB_SATURATE_EN.
module addsub_pipe #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LAT    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sub,
  input  logic [NUM_CH*DATA_W-1:0]     i_a,
  input  logic [NUM_CH*DATA_W-1:0]     i_b,
  output logic [NUM_CH*(DATA_W+1)-1:0] o_c,
  output logic [NUM_CH-1:0]            o_sat,
  output logic                         o_valid,
  input  logic                         i_ready
);

  localparam int unsigned CW = DATA_W + 1;

  if (LAT < 1) begin : g_lat_check
    $error("addsub_pipe: LAT must be at least 1");
  end

`ifdef ADDSUB_SATURATE_EN
  localparam logic [CW-1:0] MaxVal = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic [CW-1:0] MinVal = {2'b11, {(DATA_W-1){1'b0}}};
`endif

  logic [NUM_CH*CW-1:0] res_d;
  logic [NUM_CH-1:0]    sat_d;
  logic [CW-1:0]        a_ext;
  logic [CW-1:0]        b_ext;
  logic [CW-1:0]        sum;

  always_comb begin
    res_d = '0;
    sat_d = '0;
    a_ext = '0;
    b_ext = '0;
    sum   = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      a_ext = {i_a[n*DATA_W + DATA_W - 1], i_a[n*DATA_W +: DATA_W]};
      b_ext = {i_b[n*DATA_W + DATA_W - 1], i_b[n*DATA_W +: DATA_W]};
      sum   = i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
`ifdef ADDSUB_SATURATE_EN
      // Top two bits disagree exactly when the result leaves the DATA_W range.
      if (sum[CW-1] != sum[CW-2]) begin
        sat_d[n] = 1'b1;
        sum      = sum[CW-1] ? MinVal : MaxVal;
      end
`endif
      res_d[n*CW +: CW] = sum;
    end
  end

  logic [LAT-1:0]       valid_q;
  logic [NUM_CH*CW-1:0] data_q [LAT];
  logic [NUM_CH-1:0]    sat_q  [LAT];
  logic [LAT:0]         rdy;

  // Stage k may advance if downstream accepts or any stage from k onward is a bubble.
  always_comb begin
    rdy = '0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      rdy[k] = i_ready;
      for (int unsigned j = k; j < LAT; j++) begin
        if (!valid_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        data_q[k] <= '0;
        sat_q[k]  <= '0;
      end
    end else begin
      if (rdy[0]) begin
        valid_q[0] <= i_valid;
        data_q[0]  <= res_d;
        sat_q[0]   <= sat_d;
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
          sat_q[k]   <= sat_q[k-1];
        end
      end
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = valid_q[LAT-1];
  assign o_c     = data_q[LAT-1];
  assign o_sat   = sat_q[LAT-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed scoreboard bench for addsub_pipe (DATA_W=24, NUM_CH=2, LAT=2).
// Follows ADDSUB_SATURATE_EN so the reference model matches either build.
module tb_addsub_pipe;

  localparam int unsigned DW = 24;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = DW + 1;

  typedef struct packed {
    logic [NC-1:0]    sat;
    logic [NC*CW-1:0] c;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_valid;
  logic              o_ready;
  logic              i_sub;
  logic [NC*DW-1:0]  i_a;
  logic [NC*DW-1:0]  i_b;
  logic [NC*CW-1:0]  o_c;
  logic [NC-1:0]     o_sat;
  logic              o_valid;
  logic              i_ready;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic stall_pending = 1'b0;
  logic [NC*CW-1:0] hold_c;

  always #5 clk = ~clk;

  addsub_pipe #(.DATA_W(DW), .NUM_CH(NC), .LAT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sub   (i_sub),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_c     (o_c),
    .o_sat   (o_sat),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NC*DW-1:0] a, input logic [NC*DW-1:0] b,
                                 input logic s);
    exp_t e;
    logic signed [DW-1:0] as_v;
    logic signed [DW-1:0] bs_v;
    longint ai, bi, r;
`ifdef ADDSUB_SATURATE_EN
    longint maxv, minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
`endif
    e = '0;
    for (int ch = 0; ch < NC; ch++) begin
      as_v = a[ch*DW +: DW];
      bs_v = b[ch*DW +: DW];
      ai = as_v;
      bi = bs_v;
      r  = s ? (ai - bi) : (ai + bi);
`ifdef ADDSUB_SATURATE_EN
      if (r > maxv) begin
        r = maxv;
        e.sat[ch] = 1'b1;
      end else if (r < minv) begin
        r = minv;
        e.sat[ch] = 1'b1;
      end
`endif
      e.c[ch*CW +: CW] = r[CW-1:0];
    end
    return e;
  endfunction

  task automatic set_in(input logic v, input logic s, input longint a0, input longint b0,
                        input longint a1, input longint b1);
    i_valid = v;
    i_sub   = s;
    i_a     = {a1[DW-1:0], a0[DW-1:0]};
    i_b     = {b1[DW-1:0], b0[DW-1:0]};
  endtask

  // One clock: settle, check output/stability, record accepts, then step past the edge.
  task automatic cycle();
    exp_t e;
    #2;
    if (stall_pending) begin
      chk("hold_valid", {63'd0, o_valid}, 64'd1);
      chk("hold_c", 64'(o_c), 64'(hold_c));
    end
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_c", 64'(o_c), 64'(e.c));
        chk("out_sat", 64'(o_sat), 64'(e.sat));
      end
    end
    stall_pending = o_valid && !i_ready;
    hold_c        = o_c;
    if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_sub));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic acc;
    reset_n = 1'b0;
    i_ready = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    #1;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_c", 64'(o_c), 64'd0);
    chk("rst_sat", 64'(o_sat), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Traffic in flight, then an asynchronous reset discards it.
    set_in(1'b1, 1'b0, 11, 22, 33, 44);
    cycle();
    set_in(1'b1, 1'b1, 55, 66, 77, 88);
    cycle();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_c", 64'(o_c), 64'd0);
    q.delete();
    stall_pending = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", {63'd0, o_valid}, 64'd0);

    // Latency: 100-30 appears two cycles after accept.
    set_in(1'b1, 1'b1, 100, 30, 100, 30);
    #1;
    chk("lat_ready", {63'd0, o_ready}, 64'd1);
    cycle();
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    chk("lat_cyc1", {63'd0, o_valid}, 64'd0);
    cycle();
    chk("lat_cyc2", {63'd0, o_valid}, 64'd1);
    chk("lat_c70", 64'(o_c), {14'd0, 25'd70, 25'd70});
    cycle();

    // Mode/sign, back-to-back mixed modes.
    set_in(1'b1, 1'b1, -5, 7, -8388608, -1);
    cycle();
    set_in(1'b1, 1'b0, -5, 7, -8388608, -1);
    cycle();
    set_in(1'b1, 1'b1, 1234567, -7654321, -1, 1);
    cycle();
    drain();

    // Backpressure: 5 transactions, downstream stalled for 4 cycles.
    n = 0;
    for (int c = 0; c < 40 && (n < 5 || q.size() > 0); c++) begin
      i_ready = (c >= 4);
      if (n < 5) set_in(1'b1, n[0], 1000 * n, -n, -2000, 77 * n);
      else       set_in(1'b0, 1'b0, 0, 0, 0, 0);
      #1;
      if (c < 2) chk("bp_ready_open", {63'd0, o_ready}, 64'd1);
      if (c == 2 || c == 3) chk("bp_ready_full", {63'd0, o_ready}, 64'd0);
      acc = i_valid && o_ready;
      cycle();
      if (acc) n++;
    end
    chk("bp_all_sent", 64'(n), 64'd5);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Bubble collapse: a lone item slides to the output while the input stays open.
    i_ready = 1'b0;
    set_in(1'b1, 1'b0, 300, 400, -300, -400);
    cycle();
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    #1;
    chk("bub_ready1", {63'd0, o_ready}, 64'd1);
    cycle();
    #1;
    chk("bub_ready2", {63'd0, o_ready}, 64'd1);
    chk("bub_valid", {63'd0, o_valid}, 64'd1);
    cycle();
    set_in(1'b1, 1'b1, 9, 10, 11, 12);
    #1;
    chk("bub_ready3", {63'd0, o_ready}, 64'd1);
    cycle();
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    #1;
    chk("bub_full", {63'd0, o_ready}, 64'd0);
    cycle();
    drain();

    // Full throughput: 10 back-to-back subtracts.
    for (int i = 0; i < 12; i++) begin
      i_ready = 1'b1;
      if (i < 10) set_in(1'b1, 1'b1, longint'($urandom()), longint'($urandom()),
                         longint'($urandom()), longint'($urandom()));
      else        set_in(1'b0, 1'b0, 0, 0, 0, 0);
      #1;
      if (i < 10) chk("tp_ready", {63'd0, o_ready}, 64'd1);
      if (i >= 2) chk("tp_valid", {63'd0, o_valid}, 64'd1);
      cycle();
    end
    chk("tp_drained", 64'(q.size()), 64'd0);

    // Range boundary: 8388607 - (-1).
    set_in(1'b1, 1'b1, 8388607, -1, 8388607, -1);
    cycle();
    set_in(1'b0, 1'b0, 0, 0, 0, 0);
    cycle();
`ifdef ADDSUB_SATURATE_EN
    chk("sat_c", 64'(o_c[CW-1:0]), 64'd8388607);
    chk("sat_flag", 64'(o_sat), 64'd3);
`else
    chk("sat_c", 64'(o_c[CW-1:0]), 64'd8388608);
    chk("sat_flag", 64'(o_sat), 64'd0);
`endif
    cycle();
    set_in(1'b1, 1'b0, -8388608, -8388608, 8388607, 8388607);
    cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
